// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parameterised serial pattern detector.
package seq_det_pkg;

   localparam int PAT_LEN_DEF = 4;
   localparam int COUNT_W_DEF = 8;
   localparam int PAT_LEN_MIN = 2;
   localparam int PAT_LEN_MAX = 16;
   localparam int COUNT_W_MIN = 1;
   localparam int COUNT_W_MAX = 16;

   typedef enum logic {
      NON_OVERLAP = 1'b0,
      OVERLAP     = 1'b1
   } mode_e;

endpackage

// File: rtl/seq_match_counter.sv
// Saturating up-counter used to tally detector matches.
module seq_match_counter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   logic [COUNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else if (inc && (count_q != {COUNT_W{1'b1}}))
         count_q <= count_q + COUNT_W'(1);
   end

   assign count = count_q;

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern and overlap mode.
// Match counter is present only when SEQ_DET_COUNT_EN is defined.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN   = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1101,
   parameter int                 COUNT_W   = COUNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in,
   input  logic               in_valid,
   input  logic               overlap,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pattern,
   output logic               match,
   output logic [COUNT_W-1:0] match_count
);

   localparam int HIST_W = PAT_LEN - 1;
   localparam int FILL_W = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

   generate
      if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
         $error("seq_det_param: PAT_LEN %0d out of range", PAT_LEN);
      end
      if (COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_count_w
         $error("seq_det_param: COUNT_W %0d out of range", COUNT_W);
      end
   endgenerate

   logic [PAT_LEN-1:0] pat_q,  pat_d;
   logic [HIST_W-1:0]  hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               accept, full;
   mode_e              mode;

   assign mode   = mode_e'(overlap);
   assign accept = in_valid & ~pat_load;
   assign full   = (fill_q == FILL_LAST);
   // Reset forces fill to 0, which keeps match low while reset is asserted.
   assign match  = accept & full & ({hist_q, in} == pat_q);

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (pat_load) begin
         pat_d  = pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = HIST_W'({hist_q, in});
         if (match && (mode == NON_OVERLAP))
            fill_d = '0;
         else if (!full)
            fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q  <= PAT_RESET;
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

`ifdef SEQ_DET_COUNT_EN
   seq_match_counter #(
      .COUNT_W (COUNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .count (match_count)
   );
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: hand vectors, corner sequences, random vs model.
module tb_seq_det_param;

`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din, vld, ovl, ld;
   logic [3:0] pat;
   logic       m1, m2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_det_param #(.PAT_LEN(4), .PAT_RESET(4'b1101), .COUNT_W(8)) u_dut (
      .clk(clk), .reset(rst_n), .in(din), .in_valid(vld), .overlap(ovl),
      .pat_load(ld), .pattern(pat), .match(m1), .match_count(cnt1));

   seq_det_param #(.PAT_LEN(4), .PAT_RESET(4'b1101), .COUNT_W(2)) u_sat (
      .clk(clk), .reset(rst_n), .in(din), .in_valid(vld), .overlap(ovl),
      .pat_load(ld), .pattern(pat), .match(m2), .match_count(cnt2));

   // Reference model: bits accepted since the last clear, the active pattern, match tally.
   bit         mq[$];
   logic [3:0] mdl_pat;
   int         mdl_cnt;

   function automatic void mdl_reset();
      mq.delete();
      mdl_pat = 4'b1101;
      mdl_cnt = 0;
   endfunction

   function automatic logic mdl_match(logic v, logic b, logic l);
      logic [3:0] w;
      int n;
      if (!v || l) return 1'b0;
      n = mq.size();
      if (n < 3) return 1'b0;
      w = {logic'(mq[n-3]), logic'(mq[n-2]), logic'(mq[n-1]), b};
      return (w == mdl_pat);
   endfunction

   function automatic void mdl_update(logic v, logic b, logic ov, logic l, logic [3:0] pt, logic m);
      if (l) begin
         mdl_pat = pt;
         mq.delete();
      end else if (v) begin
         if (m) mdl_cnt++;
         if (m && !ov) mq.delete();
         else begin
            mq.push_back(b);
            if (mq.size() > 4) void'(mq.pop_front());
         end
      end
   endfunction

   function automatic int exp_cnt(int maxv);
      if (!CNT_EN) return 0;
      return (mdl_cnt > maxv) ? maxv : mdl_cnt;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   logic       obs_m;
   logic [7:0] obs_c;

   task automatic step(input logic v, input logic b, input logic ov, input logic l, input logic [3:0] pt);
      logic em;
      @(negedge clk);
      vld = v; din = b; ovl = ov; ld = l; pat = pt;
      #1;
      em = mdl_match(v, b, l);
      chk("match", m1, em);
      chk("match_w2", m2, em);
      chk("count", cnt1, exp_cnt(255));
      chk("count_w2", cnt2, exp_cnt(3));
      obs_m = m1;
      obs_c = cnt1;
      mdl_update(v, b, ov, l, pt, em);
   endtask

   // Asynchronous pulse mid-cycle with a tempting input applied.
   task automatic reset_pulse();
      @(negedge clk);
      vld = 1'b1; din = 1'b1; ld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_match", m1, 0);
      chk("rst_count", cnt1, 0);
      chk("rst_count_w2", cnt2, 0);
      mdl_reset();
      @(negedge clk);
      rst_n = 1'b1;
      vld = 1'b0;
   endtask

   typedef struct {
      logic v, b, ov, l;
      logic [3:0] pt;
      logic m;
      int   c;
   } vec_t;

   vec_t vecs[31];

   initial begin
      vecs = '{
         // overlap=1: 1,1,0,1,1,0,1 -> match on bits 4 and 7
         '{1,1,1,0,4'h0,0,0}, '{1,1,1,0,4'h0,0,0}, '{1,0,1,0,4'h0,0,0}, '{1,1,1,0,4'h0,1,0},
         '{1,1,1,0,4'h0,0,1}, '{1,0,1,0,4'h0,0,1}, '{1,1,1,0,4'h0,1,1},
         '{0,0,1,1,4'hD,0,2},
         // overlap=0: same bits -> match on bit 4 only
         '{1,1,0,0,4'h0,0,2}, '{1,1,0,0,4'h0,0,2}, '{1,0,0,0,4'h0,0,2}, '{1,1,0,0,4'h0,1,2},
         '{1,1,0,0,4'h0,0,3}, '{1,0,0,0,4'h0,0,3}, '{1,1,0,0,4'h0,0,3},
         '{0,0,1,1,4'hD,0,3},
         // 1,1, three idle cycles, 0,1 -> match on the final bit
         '{1,1,1,0,4'h0,0,3}, '{1,1,1,0,4'h0,0,3}, '{0,0,1,0,4'h0,0,3}, '{0,1,1,0,4'h0,0,3},
         '{0,1,1,0,4'h0,0,3}, '{1,0,1,0,4'h0,0,3}, '{1,1,1,0,4'h0,1,3},
         // 1,1,0 then load 1011 while the old pattern would match, then 1,0,1,1
         '{1,1,1,0,4'h0,0,4}, '{1,1,1,0,4'h0,0,4}, '{1,0,1,0,4'h0,0,4}, '{1,1,1,1,4'hB,0,4},
         '{1,1,1,0,4'h0,0,4}, '{1,0,1,0,4'h0,0,4}, '{1,1,1,0,4'h0,0,4}, '{1,1,1,0,4'h0,1,4}
      };

      rst_n = 1'b0; din = 1'b0; vld = 1'b0; ovl = 1'b0; ld = 1'b0; pat = 4'h0;
      mdl_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_match", m1, 0);
      chk("reset_count", cnt1, 0);
      chk("reset_count_w2", cnt2, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 31; i++) begin
         step(vecs[i].v, vecs[i].b, vecs[i].ov, vecs[i].l, vecs[i].pt);
         chk($sformatf("vec%0d_match", i), obs_m, vecs[i].m);
         chk($sformatf("vec%0d_count", i), obs_c, CNT_EN ? vecs[i].c : 0);
      end
      step(0, 0, 1, 0, 4'h0);
      chk("table_total", obs_c, CNT_EN ? 5 : 0);

      // Reset mid-sequence discards 1,1,0; detection restarts afterwards.
      reset_pulse();
      step(1, 1, 1, 0, 4'h0);
      step(1, 1, 1, 0, 4'h0);
      step(1, 0, 1, 0, 4'h0);
      reset_pulse();
      step(1, 1, 1, 0, 4'h0);
      chk("post_rst_nomatch", obs_m, 0);
      step(1, 1, 1, 0, 4'h0);
      step(1, 0, 1, 0, 4'h0);
      step(1, 1, 1, 0, 4'h0);
      chk("post_rst_match", obs_m, 1);

      // 1101101101101101 with overlap: 5 matches, 2-bit counter saturates at 3.
      reset_pulse();
      begin
         logic [15:0] s;
         int nm;
         s = 16'b1101101101101101;
         nm = 0;
         for (int i = 15; i >= 0; i--) begin
            step(1, s[i], 1, 0, 4'h0);
            if (obs_m) nm++;
         end
         step(0, 0, 1, 0, 4'h0);
         chk("sat_matches", nm, 5);
         chk("sat_count_w8", cnt1, CNT_EN ? 5 : 0);
         chk("sat_count_w2", cnt2, CNT_EN ? 3 : 0);
      end

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) reset_pulse();
         step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 24) == 0),
              4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
